// File: rtl/move_input_ctrl.sv
// Direction-button conditioner: synchronise, debounce, fixed-priority encode,
// and emit one-clock moves on the game tick with collision knockback lockout.
module move_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned TICK_CYCLES     = 416667,
    parameter int unsigned LOCKOUT_TICKS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       enemy_collide,
    output logic [3:0] move_dir,
    output logic       move_tick,
    output logic [3:0] held,
    output logic       locked
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TICK_CYCLES + 1);
    localparam int unsigned LW = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_CYCLES - 2);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_TICKS);

    logic [3:0]    raw_c;
    logic [3:0]    sync_q1;
    logic [3:0]    sync_q2;
    logic [DW-1:0] db_cnt [4];
    logic [TW-1:0] tick_cnt;
    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_cnt_next_c;
    logic [3:0]    enc_c;

    assign raw_c = {btn_up, btn_down, btn_left, btn_right};

    // Two-flop synchroniser for the asynchronous buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw_c;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce: held[i] follows the synced level only after it has disagreed long enough
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
            held <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_q2[i] == held[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    held[i]   <= ~held[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Tick counter; move_tick is registered one count early so it lines up with TICK_LAST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            move_tick <= 1'b0;
        end else begin
            tick_cnt  <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
            move_tick <= (tick_cnt == TICK_PRE);
        end
    end

    // Fixed priority up > down > left > right
    always_comb begin
        enc_c = 4'b0000;
        if (held[3]) begin
            enc_c = 4'b1000;
        end else if (held[2]) begin
            enc_c = 4'b0100;
        end else if (held[1]) begin
            enc_c = 4'b0010;
        end else if (held[0]) begin
            enc_c = 4'b0001;
        end
    end

    // Collision reload takes precedence over the per-tick decrement
    always_comb begin
        lock_cnt_next_c = lock_cnt;
        if (enemy_collide) begin
            lock_cnt_next_c = LOCK_LOAD;
        end else if (move_tick && (lock_cnt != '0)) begin
            lock_cnt_next_c = lock_cnt - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            lock_cnt <= lock_cnt_next_c;
            locked   <= (lock_cnt_next_c != '0);
        end
    end

    // One-clock move following each tick unless locked out or a collision is arriving
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_dir <= '0;
        end else if (move_tick && !locked && !enemy_collide) begin
            move_dir <= enc_c;
        end else begin
            move_dir <= '0;
        end
    end

endmodule

// File: tb/tb_move_input_ctrl.sv
// Bench for move_input_ctrl: reference model feeds a scoreboard, monitor compares at negedge.
module tb_move_input_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned TK = 10;
    localparam int unsigned LK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       enemy_collide;
    logic [3:0] move_dir;
    logic       move_tick;
    logic [3:0] held;
    logic       locked;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] held;
        logic       locked;
        logic       tick;
        logic [3:0] move;
    } obs_t;

    obs_t       exp_q  [$];
    logic [3:0] move_q [$];

    // Reference model state
    logic [3:0] hist [$];
    logic [3:0] m_held;
    int         m_lock;
    bit         m_tick;
    logic [3:0] m_move;
    int         m_n;

    move_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_CYCLES    (TK),
        .LOCKOUT_TICKS  (LK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .enemy_collide(enemy_collide),
        .move_dir     (move_dir),
        .move_tick    (move_tick),
        .held         (held),
        .locked       (locked)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] highest(input logic [3:0] v);
        for (int b = 3; b >= 0; b--) begin
            if (v[b]) return 4'(1 << b);
        end
        return 4'b0000;
    endfunction

    // Spec-level model: a button's debounced level flips once the last DEBOUNCE_CYCLES
    // synchronised samples (raw delayed two clocks) all disagree with it.
    task automatic model_step();
        obs_t       o;
        logic [3:0] nxt_move;
        logic       seen;
        bit         all_opp;
        if (rst) begin
            hist.delete();
            m_held = '0;
            m_lock = 0;
            m_tick = 1'b0;
            m_move = '0;
            m_n    = 0;
        end else begin
            m_n++;
            nxt_move = (m_tick && m_lock == 0 && !enemy_collide) ? highest(m_held) : 4'b0000;
            if (enemy_collide) m_lock = int'(LK);
            else if (m_tick && m_lock > 0) m_lock--;
            hist.push_front({btn_up, btn_down, btn_left, btn_right});
            if (hist.size() > int'(DB) + 2) void'(hist.pop_back());
            for (int i = 0; i < 4; i++) begin
                all_opp = 1'b1;
                for (int k = 2; k < int'(DB) + 2; k++) begin
                    seen = (k < hist.size()) ? hist[k][i] : 1'b0;
                    if (seen == m_held[i]) all_opp = 1'b0;
                end
                if (all_opp) m_held[i] = ~m_held[i];
            end
            m_tick = ((m_n % int'(TK)) == int'(TK) - 1);
            m_move = nxt_move;
            if (nxt_move != 4'b0000) move_q.push_back(nxt_move);
        end
        o.held   = m_held;
        o.locked = (m_lock > 0);
        o.tick   = m_tick;
        o.move   = m_move;
        exp_q.push_back(o);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: compare every cycle's state, and every presented move against the move queue
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue expected a record at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("held", held, e.held);
                check("locked", 4'(locked), 4'(e.locked));
                check("move_tick", 4'(move_tick), 4'(e.tick));
                check("move_dir", move_dir, e.move);
            end
            if (move_dir != 4'b0000) begin
                if (move_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL move_event: got %b expected no move at %0t", move_dir, $time);
                end else begin
                    check("move_event", move_dir, move_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    // Outputs must clear as soon as reset asserts, not at the next edge
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        #1;
        check("rst_move_dir", move_dir, 4'b0000);
        check("rst_held", held, 4'b0000);
        check("rst_locked", 4'(locked), 4'b0000);
        check("rst_move_tick", 4'(move_tick), 4'b0000);
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    // With btn_up already applied at reset release, held[3] rises on the 6th edge
    task automatic press_latency(input string tag);
        repeat (5) step();
        check({tag, "_held_before"}, held, 4'b0000);
        step();
        check({tag, "_held_after"}, held, 4'b1000);
    endtask

    initial begin
        logic [3:0] b;
        rst = 1'b1;
        enemy_collide = 1'b0;
        set_btns(4'b0000);
        repeat (2) step();

        // Up held from reset
        set_btns(4'b1000);
        rst = 1'b0;
        press_latency("up");
        repeat (30) step();

        // Short left glitch is ignored
        step();
        do_reset(2);
        set_btns(4'b0010);
        repeat (3) step();
        set_btns(4'b0000);
        repeat (25) step();
        check("glitch_held", held, 4'b0000);

        // Down+right, then add up
        set_btns(4'b0101);
        repeat (30) step();
        set_btns(4'b1101);
        repeat (30) step();

        // Right held, single collision pulse
        set_btns(4'b0001);
        repeat (20) step();
        enemy_collide = 1'b1;
        step();
        enemy_collide = 1'b0;
        check("collide_locked", 4'(locked), 4'b0001);
        repeat (45) step();

        // Collision re-pulsed after the first locked tick
        enemy_collide = 1'b1;
        step();
        enemy_collide = 1'b0;
        repeat (12) step();
        enemy_collide = 1'b1;
        step();
        enemy_collide = 1'b0;
        repeat (50) step();

        // Reset while locked with up held
        set_btns(4'b1000);
        repeat (10) step();
        enemy_collide = 1'b1;
        step();
        enemy_collide = 1'b0;
        repeat (3) step();
        do_reset(2);
        press_latency("rst_up");
        repeat (30) step();

        // Randomised buttons, collisions and occasional resets
        b = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) b[i] = ~b[i];
            end
            set_btns(b);
            enemy_collide = ($urandom_range(79) == 0);
            if ($urandom_range(599) == 0) do_reset(int'($urandom_range(3, 1)));
        end
        enemy_collide = 1'b0;
        repeat (3) step();

        n_checks++;
        if (move_q.size() != 0) begin
            n_fail++;
            $display("FAIL moves_drained: got %0d pending expected 0", move_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
